// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the multi-cycle ALU.
// Imported by the interface-facing top and the combinational core.
package alu_seq_muldiv_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // True for the opcodes that finish in one cycle through the combinational core
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Request/response bundle between the register-read stage and the ALU.
// The pipeline side uses master, the ALU uses slave.
interface alu_seq_muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  lo, hi, zero, overflow, div_by_zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output lo, hi, zero, overflow, div_by_zero, busy, done
    );

endinterface

// File: rtl/alu_seq_muldiv_comb_core.sv
// Combinational AND/OR/ADD/SUB/SLT core with signed overflow and carry out.
// The divider borrows it for its trial subtraction, where carry_out=1 means no borrow.
module alu_seq_muldiv_comb_core
    import alu_seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             sum_msb;

    always_comb begin
        sub       = (op == OP_SUB) || (op == OP_SLT);
        b_eff     = sub ? ~b : b;
        sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        carry_out = sum_ext[WIDTH];
        sum_msb   = sum_ext[WIDTH-1];
        overflow  = (a[WIDTH-1] ^ sum_msb) & (b_eff[WIDTH-1] ^ sum_msb);
        case (op)
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_ADD, OP_SUB: result = sum_ext[WIDTH-1:0];
            OP_SLT:         result = {{(WIDTH-1){1'b0}}, sum_msb ^ overflow};
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus bit-serial MULTU and restoring DIVU.
// Result registers only change when an operation completes, so they hold while busy.
module alu_seq_muldiv
    import alu_seq_muldiv_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_muldiv_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [3:0]       core_op;
    logic [WIDTH-1:0] core_a, core_b, core_res;
    logic             core_ovf, core_cout;

    logic             accept, last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_quo;
    logic             div_ok;
    logic [WIDTH-1:0] div_acc, div_quo;

    alu_seq_muldiv_comb_core #(.WIDTH(WIDTH)) u_core (
        .op        (core_op),
        .a         (core_a),
        .b         (core_b),
        .result    (core_res),
        .overflow  (core_ovf),
        .carry_out (core_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    // While dividing, the core subtracts the divisor from the shifted partial remainder
    always_comb begin
        accept = ((state_q == IDLE) || (state_q == FIN)) && bus.start;
        last   = (cnt_q == CNT_W'(WIDTH - 1));
        if (state_q == DIV) begin
            core_op = OP_SUB;
            core_a  = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
            core_b  = opnd_q;
        end else begin
            core_op = bus.op;
            core_a  = bus.a;
            core_b  = bus.b;
        end
        mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc = mul_sum[WIDTH:1];
        mul_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
        // A set remainder MSB means the shifted value exceeds any divisor
        div_ok  = core_cout | acc_q[WIDTH-1];
        div_acc = div_ok ? core_res : core_a;
        div_quo = {quo_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (bus.op == OP_MULTU) begin
                        state_d = MUL;
                        opnd_d  = bus.a;
                        quo_d   = bus.b;
                    end else if ((bus.op == OP_DIVU) && (bus.b != '0)) begin
                        state_d = DIV;
                        opnd_d  = bus.b;
                        quo_d   = bus.a;
                    end else begin
                        state_d = FIN;
                        lo_d    = '0;
                        hi_d    = '0;
                        zero_d  = 1'b0;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b0;
                        if (bus.op == OP_DIVU) begin
                            lo_d  = '1;
                            hi_d  = bus.a;
                            dbz_d = 1'b1;
                        end else if (is_alu_op(bus.op)) begin
                            lo_d   = core_res;
                            zero_d = (core_res == '0);
                            ovf_d  = ((bus.op == OP_ADD) || (bus.op == OP_SUB)) & core_ovf;
                        end
                    end
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = (state_q == MUL) ? mul_acc : div_acc;
                quo_d = (state_q == MUL) ? mul_quo : div_quo;
                if (last) begin
                    state_d = FIN;
                    lo_d    = quo_d;
                    hi_d    = acc_d;
                    zero_d  = (quo_d == '0);
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q == MUL) || (state_q == DIV);
        bus.done        = (state_q == FIN);
        bus.lo          = lo_q;
        bus.hi          = hi_q;
        bus.zero        = zero_q;
        bus.overflow    = ovf_q;
        bus.div_by_zero = dbz_q;
    end

endmodule
